// File: rtl/mem_pkg.sv
// mem_pkg: buffer-memory constants shared by the datapath blocks.
//   ADDR_W : width of a buffer-memory start pointer.
package mem_pkg;
  localparam int ADDR_W = 10;
endpackage

// File: rtl/egress_ptr_queue_if.sv
// egress_ptr_queue_if: groups the enqueue side and the per-port egress
// handshake of egress_ptr_queue.
//   master : the environment (forwarding translator + egress readers);
//            drives write_reqs_i, start_ptrs_i and egress_ready_i.
//   slave  : the queue block; drives the egress head, occupancy and drop status.
// Handshake (per port p): egress_valid_o[p] says the head is present,
// egress_ready_i[p] says the reader takes it; a pop happens on a clock edge
// where both are high. egress_ptr_o[p] holds steady while valid is high and
// ready is low. egress_ready_i may be high while valid is low (no effect).
interface egress_ptr_queue_if #(
  parameter int NUM_PORTS = 4,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = mem_pkg::ADDR_W
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NUM_PORTS-1:0] write_reqs_i;
  logic [ADDR_W-1:0]    start_ptrs_i [NUM_PORTS-1:0];
  logic [NUM_PORTS-1:0] egress_valid_o;
  logic [ADDR_W-1:0]    egress_ptr_o [NUM_PORTS-1:0];
  logic [NUM_PORTS-1:0] egress_ready_i;
  logic [CNT_W-1:0]     count_o [NUM_PORTS-1:0];
  logic [NUM_PORTS-1:0] full_o;
  logic [NUM_PORTS-1:0] drop_o;
  logic [15:0]          drop_count_o [NUM_PORTS-1:0];

  modport master (
    output write_reqs_i, start_ptrs_i, egress_ready_i,
    input  egress_valid_o, egress_ptr_o, count_o, full_o, drop_o, drop_count_o
  );

  modport slave (
    input  write_reqs_i, start_ptrs_i, egress_ready_i,
    output egress_valid_o, egress_ptr_o, count_o, full_o, drop_o, drop_count_o
  );
endinterface

// File: rtl/egress_ptr_queue.sv
// egress_ptr_queue: one independent first-word-fall-through FIFO of frame
// start pointers per egress port. A flood (several strobes in one cycle)
// enqueues the same-cycle pointers into each strobed port.
//
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset (released synchronously upstream)
//   q     : egress_ptr_queue_if.slave -- enqueue strobes/pointers, egress
//           valid/ready/pointer, occupancy, full, drop pulse, drop counters.
//
// Parameters: NUM_PORTS ports, DEPTH entries per port (power of 2, >= 2),
// ADDR_W pointer width.
//
// Build option: define EGRESS_DROP_STATS_EN to build a saturating 16-bit
// drop counter per port; otherwise drop_count_o is tied to zero.
module egress_ptr_queue #(
  parameter int NUM_PORTS = 4,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = mem_pkg::ADDR_W
) (
  input logic               clk,
  input logic               rst_n,
  egress_ptr_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              drop_q;
    logic              full;
    logic              push;
    logic              pop;
    logic              accept;
    logic              reject;

    assign full   = (count == CNT_W'(DEPTH));
    assign push   = q.write_reqs_i[p];
    assign pop    = (count != '0) && q.egress_ready_i[p];
    // A pop in the same cycle frees the slot the push is about to use.
    assign accept = push && (!full || pop);
    assign reject = push && full && !pop;

    // Storage carries no reset; validity is governed solely by count.
    always_ff @(posedge clk) begin
      if (accept) begin
        mem[wr_ptr] <= q.start_ptrs_i[p];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        drop_q <= 1'b0;
      end else begin
        // Pointers are PTR_W bits wide, so +1 wraps modulo DEPTH.
        if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
        if (accept && !pop) begin
          count <= count + CNT_W'(1);
        end else if (pop && !accept) begin
          count <= count - CNT_W'(1);
        end
        drop_q <= reject;
      end
    end

`ifdef EGRESS_DROP_STATS_EN
    logic [15:0] drop_cnt;

    // Updates on the same edge that raises drop_q, so both are seen together.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        drop_cnt <= '0;
      end else if (reject && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end

    assign q.drop_count_o[p] = drop_cnt;
`else
    assign q.drop_count_o[p] = '0;
`endif

    // All status outputs come from registered state only.
    assign q.egress_valid_o[p] = (count != '0);
    assign q.egress_ptr_o[p]   = mem[rd_ptr];
    assign q.count_o[p]        = count;
    assign q.full_o[p]         = full;
    assign q.drop_o[p]         = drop_q;
  end
endmodule
